// File: rtl/megadrive_pad_pkg.sv
// rtl/megadrive_pad_pkg.sv - shared Mega Drive pad button/pin indices and phase constants
package megadrive_pad_pkg;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_B = 4;
    localparam int BTN_C = 5;
    localparam int BTN_A = 6;
    localparam int BTN_S = 7;
    localparam int BTN_Z = 8;
    localparam int BTN_Y = 9;
    localparam int BTN_X = 10;
    localparam int BTN_M = 11;

    localparam int PIN_RIGHT = 0;
    localparam int PIN_LEFT  = 1;
    localparam int PIN_DOWN  = 2;
    localparam int PIN_UP    = 3;
    localparam int PIN_P6    = 4;
    localparam int PIN_P9    = 5;

    localparam logic [2:0] CNT_EXT = 3'd3;
    localparam logic [2:0] CNT_SAT = 3'd4;

endpackage

// File: rtl/sel_sync_edge.sv
// rtl/sel_sync_edge.sv - N-stage synchronizer with rise/fall pulse outputs
module sel_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              dly_q;
    logic              dly_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
        dly_d  = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = ~dly_q & sync_q[STAGES-1];
    assign fall_o = dly_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/megadrive_pad_responder.sv
// rtl/megadrive_pad_responder.sv - device-side Mega Drive 3/6-button pad emulator
module megadrive_pad_responder
    import megadrive_pad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 18000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        six_btn_i,
    input  logic [11:0] btn_i,
    input  logic        sel_i,
    output logic [5:0]  db9_o,
    output logic        seq_active_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          sel_s;
    logic          sel_rise;
    logic          sel_fall;
    logic [2:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [5:0]    db9_q, db9_d;
    logic [5:0]    pins;

    sel_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sel_sync (
        .clk    (clk_sys),
        .rst    (reset),
        .d_i    (sel_i),
        .sync_o (sel_s),
        .rise_o (sel_rise),
        .fall_o (sel_fall)
    );

    // An edge always wins over a coincident timeout.
    always_comb begin
        cnt_d   = cnt_q;
        timer_d = timer_q;
        if (sel_fall || sel_rise) begin
            timer_d = '0;
            if (sel_fall && (cnt_q < CNT_SAT)) begin
                cnt_d = cnt_q + 3'd1;
            end
        end else if (cnt_q != 3'd0) begin
            if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                cnt_d   = '0;
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // Phase is taken from cnt_d so the new phase lands together with the select level.
    always_comb begin
        pins = '0;
        if (sel_s) begin
            pins[PIN_P9] = btn_i[BTN_C];
            pins[PIN_P6] = btn_i[BTN_B];
            if (six_btn_i && (cnt_d == CNT_EXT)) begin
                pins[PIN_UP]    = btn_i[BTN_Z];
                pins[PIN_DOWN]  = btn_i[BTN_Y];
                pins[PIN_LEFT]  = btn_i[BTN_X];
                pins[PIN_RIGHT] = btn_i[BTN_M];
            end else begin
                pins[PIN_UP]    = btn_i[BTN_U];
                pins[PIN_DOWN]  = btn_i[BTN_D];
                pins[PIN_LEFT]  = btn_i[BTN_L];
                pins[PIN_RIGHT] = btn_i[BTN_R];
            end
        end else begin
            pins[PIN_P9] = btn_i[BTN_S];
            pins[PIN_P6] = btn_i[BTN_A];
            if (six_btn_i && (cnt_d == CNT_EXT)) begin
                pins[PIN_UP]    = 1'b1;
                pins[PIN_DOWN]  = 1'b1;
                pins[PIN_LEFT]  = 1'b1;
                pins[PIN_RIGHT] = 1'b1;
            end else if (!(six_btn_i && (cnt_d == CNT_SAT))) begin
                pins[PIN_UP]    = btn_i[BTN_U];
                pins[PIN_DOWN]  = btn_i[BTN_D];
                pins[PIN_LEFT]  = 1'b1;
                pins[PIN_RIGHT] = 1'b1;
            end
        end
        db9_d = ~pins;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            timer_q <= '0;
            db9_q   <= 6'h3F;
        end else begin
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            db9_q   <= db9_d;
        end
    end

    assign db9_o        = db9_q;
    assign seq_active_o = (cnt_q != 3'd0);

endmodule

// File: tb/tb_megadrive_pad_responder.sv
// tb/tb_megadrive_pad_responder.sv - directed self-checking bench for megadrive_pad_responder
module tb_megadrive_pad_responder;

    localparam int TO = 200;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        six_btn_i;
    logic [11:0] btn_i;
    logic        sel_i;
    logic [5:0]  db9_o;
    logic        seq_active_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    megadrive_pad_responder #(
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .six_btn_i    (six_btn_i),
        .btn_i        (btn_i),
        .sel_i        (sel_i),
        .db9_o        (db9_o),
        .seq_active_o (seq_active_o)
    );

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk_db9(input string tag, input logic [5:0] exp);
        checks++;
        assert (db9_o === exp) else begin
            errors++;
            $error("FAIL %s db9_o observed %h expected %h", tag, db9_o, exp);
        end
    endtask

    task automatic chk_act(input string tag, input logic exp);
        checks++;
        assert (seq_active_o === exp) else begin
            errors++;
            $error("FAIL %s seq_active_o observed %b expected %b", tag, seq_active_o, exp);
        end
    endtask

    task automatic pair(input string tag, input logic [5:0] lo, input logic [5:0] hi);
        sel_i = 1'b0;
        wait_cyc(20);
        chk_db9($sformatf("%s_lo", tag), lo);
        sel_i = 1'b1;
        wait_cyc(20);
        chk_db9($sformatf("%s_hi", tag), hi);
    endtask

    initial begin
        reset     = 1'b1;
        six_btn_i = 1'b1;
        btn_i     = 12'h000;
        sel_i     = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(1);
        chk_db9("rst_db9", 6'h3F);
        chk_act("rst_act", 1'b0);
        wait_cyc(2 * TO);
        chk_db9("idle_db9", 6'h3F);
        chk_act("idle_act", 1'b0);

        btn_i = 12'h001;
        wait_cyc(1);
        chk_db9("btn_lat", 6'h37);
        btn_i = 12'h000;
        wait_cyc(1);

        btn_i = 12'h0FF;
        pair("all1", 6'h00, 6'h00);
        pair("all2", 6'h00, 6'h00);
        pair("all3", 6'h00, 6'h0F);
        pair("all4", 6'h0F, 6'h00);
        chk_act("all_act", 1'b1);
        wait_cyc(TO + 10);
        chk_act("all_to", 1'b0);

        btn_i = 12'h800;
        pair("m1", 6'h3C, 6'h3F);
        pair("m2", 6'h3C, 6'h3F);
        pair("m3", 6'h30, 6'h3E);
        pair("m4", 6'h3F, 6'h3F);
        pair("m5sat", 6'h3F, 6'h3F);
        wait_cyc(TO + 10);

        six_btn_i = 1'b0;
        pair("s1", 6'h3C, 6'h3F);
        pair("s2", 6'h3C, 6'h3F);
        pair("s3", 6'h3C, 6'h3F);
        pair("s4", 6'h3C, 6'h3F);
        wait_cyc(TO + 10);

        six_btn_i = 1'b1;
        btn_i     = 12'h000;
        sel_i     = 1'b0;
        wait_cyc(2);
        chk_db9("sel_lat2", 6'h3F);
        wait_cyc(1);
        chk_db9("sel_lat3", 6'h3C);
        wait_cyc(17);
        sel_i = 1'b1;
        wait_cyc(20);
        sel_i = 1'b0;
        wait_cyc(TO + 2);
        chk_act("stall_pre", 1'b1);
        wait_cyc(1);
        chk_act("stall_drop", 1'b0);
        wait_cyc(2);
        chk_db9("stall_db9", 6'h3C);
        sel_i = 1'b1;
        wait_cyc(20);
        sel_i = 1'b0;
        wait_cyc(20);
        chk_db9("restart_lo", 6'h3C);
        chk_act("restart_act", 1'b1);
        sel_i = 1'b1;
        wait_cyc(20);
        wait_cyc(TO + 10);

        btn_i = 12'h800;
        pair("r1", 6'h3C, 6'h3F);
        pair("r2", 6'h3C, 6'h3F);
        pair("r3", 6'h30, 6'h3E);
        reset = 1'b1;
        #1;
        chk_db9("async_rst_db9", 6'h3F);
        chk_act("async_rst_act", 1'b0);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
        pair("p1", 6'h3C, 6'h3F);
        pair("p2", 6'h3C, 6'h3F);
        pair("p3", 6'h30, 6'h3E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
